// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the DAC sample scheduler and its tick generator.
package dac_sched_pkg;

    localparam int unsigned DATA_W = 12;
    localparam int unsigned MODE_W = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    localparam logic [DATA_W-1:0] MIDSCALE  = 12'h800;
    localparam logic [MODE_W-1:0] CHMODE_ON = 2'b00;
    localparam logic [MODE_W-1:0] CHMODE_1K = 2'b01;

    // One channel's payload as handed to the DAC driver.
    typedef struct packed {
        logic [DATA_W-1:0] code;
        logic [MODE_W-1:0] mode;
    } dac_ch_t;

    localparam dac_ch_t CH_RESET = '{MIDSCALE, CHMODE_ON};

    // Two's complement to offset binary is a flip of the sign bit.
    function automatic logic [DATA_W-1:0] to_offset_bin(input logic [DATA_W-1:0] s);
        return s ^ MIDSCALE;
    endfunction

    function automatic logic [MODE_W-1:0] mode_for(input logic mute_bit);
        return mute_bit ? CHMODE_1K : CHMODE_ON;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Free-running divider emitting a registered one-cycle tick every SAMPLE_DIV clocks;
// the first tick appears SAMPLE_DIV cycles after reset is released.
module sample_tick_gen #(
    parameter int unsigned SAMPLE_DIV = 2500
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (cnt_q == CNT_W'(SAMPLE_DIV - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/dac_sample_scheduler.sv
// Snapshots filter outputs on each sample tick and handshakes them to the DAC driver.
// Optional TEST_PATTERN_EN adds test_en, which substitutes a per-tick ramp for the samples.
module dac_sample_scheduler
    import dac_sched_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV   = 2500,
    parameter int unsigned BUSY_TIMEOUT = 64,
    parameter int unsigned OVR_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_valid,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_valid,
    input  logic [1:0]        mute,
    input  logic              clr_err,
    input  logic              working,
`ifdef TEST_PATTERN_EN
    input  logic              test_en,
`endif
    output logic              update,
    output logic [DATA_W-1:0] value0,
    output logic [DATA_W-1:0] value1,
    output logic [MODE_W-1:0] chmode0,
    output logic [MODE_W-1:0] chmode1,
    output logic              sample_tick,
    output logic              overrun,
    output logic              timeout,
    output logic [OVR_W-1:0]  ovr_cnt
);

    localparam int unsigned TMO_W = $clog2(BUSY_TIMEOUT + 1);

    logic tick;

    sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    state_e            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [DATA_W-1:0] h0_q, h0_d, h1_q, h1_d;
    dac_ch_t           ch0_q, ch0_d, ch1_q, ch1_d;
    logic              update_q, update_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic [OVR_W-1:0]  ovr_cnt_q, ovr_cnt_d;
`ifdef TEST_PATTERN_EN
    logic [DATA_W-1:0] ramp_q, ramp_d;
`endif

    // Next-state, snapshot and error-flag logic.
    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        h0_d      = s0_valid ? s0_data : h0_q;
        h1_d      = s1_valid ? s1_data : h1_q;
        ch0_d     = ch0_q;
        ch1_d     = ch1_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        ovr_cnt_d = ovr_cnt_q;
`ifdef TEST_PATTERN_EN
        ramp_d    = ramp_q;
`endif

        // Clear first so a same-cycle drop still leaves a count of one.
        if (clr_err) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
            ovr_cnt_d = '0;
        end
        if (tick && (state_q != IDLE)) begin
            overrun_d = 1'b1;
            if (ovr_cnt_d != {OVR_W{1'b1}}) begin
                ovr_cnt_d = ovr_cnt_d + OVR_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (tick) begin
                    // h*_d already carries a coincident strobe's data.
                    ch0_d.code = to_offset_bin(h0_d);
                    ch1_d.code = to_offset_bin(h1_d);
`ifdef TEST_PATTERN_EN
                    if (test_en) begin
                        ch0_d.code = ramp_q;
                        ch1_d.code = ~ramp_q;
                        ramp_d     = ramp_q + DATA_W'(1);
                    end
`endif
                    ch0_d.mode = mode_for(mute[0]);
                    ch1_d.mode = mode_for(mute[1]);
                    tmo_d      = '0;
                    state_d    = working ? WAIT_BUSY : ARM;
                end
            end
            ARM, WAIT_BUSY: begin
                if (working) begin
                    state_d = WAIT_DONE;
                end else if (tmo_q == TMO_W'(BUSY_TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!working) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        update_d = (state_d == ARM) || (state_d == WAIT_BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            tmo_q     <= '0;
            h0_q      <= '0;
            h1_q      <= '0;
            ch0_q     <= CH_RESET;
            ch1_q     <= CH_RESET;
            update_q  <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            ovr_cnt_q <= '0;
`ifdef TEST_PATTERN_EN
            ramp_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            h0_q      <= h0_d;
            h1_q      <= h1_d;
            ch0_q     <= ch0_d;
            ch1_q     <= ch1_d;
            update_q  <= update_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            ovr_cnt_q <= ovr_cnt_d;
`ifdef TEST_PATTERN_EN
            ramp_q    <= ramp_d;
`endif
        end
    end

    assign update      = update_q;
    assign value0      = ch0_q.code;
    assign value1      = ch1_q.code;
    assign chmode0     = ch0_q.mode;
    assign chmode1     = ch1_q.mode;
    assign sample_tick = tick;
    assign overrun     = overrun_q;
    assign timeout     = timeout_q;
    assign ovr_cnt     = ovr_cnt_q;

endmodule

// File: tb/tb_dac_sample_scheduler.sv
// Self-checking bench for dac_sample_scheduler: directed scenarios then random traffic,
// every cycle compared against a transaction-level model of the scheduler.
module tb_dac_sample_scheduler;

    localparam int unsigned SD   = 40;
    localparam int unsigned BT   = 64;
    localparam int unsigned OW   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] s0_data = '0;
    logic        s0_valid = 1'b0;
    logic [11:0] s1_data = '0;
    logic        s1_valid = 1'b0;
    logic [1:0]  mute = 2'b00;
    logic        clr_err = 1'b0;
    logic        working = 1'b0;
    logic        test_en = 1'b0;
    logic        update;
    logic [11:0] value0, value1;
    logic [1:0]  chmode0, chmode1;
    logic        sample_tick, overrun, timeout;
    logic [OW-1:0] ovr_cnt;

    always #5 clk = ~clk;

    dac_sample_scheduler #(.SAMPLE_DIV(SD), .BUSY_TIMEOUT(BT), .OVR_W(OW)) dut (
        .clk         (clk),
        .rst         (rst),
        .s0_data     (s0_data),
        .s0_valid    (s0_valid),
        .s1_data     (s1_data),
        .s1_valid    (s1_valid),
        .mute        (mute),
        .clr_err     (clr_err),
        .working     (working),
`ifdef TEST_PATTERN_EN
        .test_en     (test_en),
`endif
        .update      (update),
        .value0      (value0),
        .value1      (value1),
        .chmode0     (chmode0),
        .chmode1     (chmode1),
        .sample_tick (sample_tick),
        .overrun     (overrun),
        .timeout     (timeout),
        .ovr_cnt     (ovr_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycles since reset, transfer-in-flight flag, driver-seen flag.
    int          m_cyc = 0;
    bit          m_tick = 0, m_busy = 0, m_seen = 0, m_upd = 0;
    int          m_arm = 0;
    logic [11:0] m_h0 = '0, m_h1 = '0, m_v0 = 12'h800, m_v1 = 12'h800, m_ramp = '0;
    logic [1:0]  m_c0 = '0, m_c1 = '0;
    bit          m_ovr = 0, m_tmo = 0;
    int          m_cnt = 0;

    // Emulated DAC driver.
    bit rnd_en = 0, drv_never = 0;
    int drv_delay = 3, drv_len = 20, wait_left = -1, hold_left = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_edge();
        bit t, was_busy;
        logic [11:0] src0, src1;
        if (rst) begin
            m_cyc = 0; m_tick = 0; m_busy = 0; m_seen = 0; m_arm = 0;
            m_h0 = '0; m_h1 = '0; m_v0 = 12'h800; m_v1 = 12'h800; m_c0 = '0; m_c1 = '0;
            m_ovr = 0; m_tmo = 0; m_cnt = 0; m_ramp = '0;
        end else begin
            t = m_tick;
            was_busy = m_busy;
            if (clr_err) begin m_ovr = 0; m_tmo = 0; m_cnt = 0; end
            if (t && was_busy) begin
                m_ovr = 1;
                if (m_cnt < 255) m_cnt++;
            end
            if (was_busy) begin
                if (!m_seen) begin
                    if (working) m_seen = 1;
                    else begin
                        m_arm++;
                        if (m_arm == BT) begin m_tmo = 1; m_busy = 0; end
                    end
                end else if (!working) begin
                    m_busy = 0;
                end
            end else if (t) begin
                src0 = s0_valid ? s0_data : m_h0;
                src1 = s1_valid ? s1_data : m_h1;
                m_v0 = 12'(int'($signed(src0)) + 2048);
                m_v1 = 12'(int'($signed(src1)) + 2048);
`ifdef TEST_PATTERN_EN
                if (test_en) begin
                    m_v0 = m_ramp;
                    m_v1 = 12'(4095 - int'(m_ramp));
                    m_ramp = 12'((int'(m_ramp) + 1) % 4096);
                end
`endif
                m_c0 = mute[0] ? 2'b01 : 2'b00;
                m_c1 = mute[1] ? 2'b01 : 2'b00;
                m_busy = 1; m_seen = 0; m_arm = 0;
            end
            if (s0_valid) m_h0 = s0_data;
            if (s1_valid) m_h1 = s1_data;
            m_cyc++;
            m_tick = (m_cyc % SD == 0);
        end
        m_upd = m_busy && !m_seen;
    endtask

    task automatic drive_next();
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        clr_err  = 1'b0;
        if (rst) begin
            working = 1'b0; wait_left = -1;
        end else if (working) begin
            hold_left--;
            if (hold_left <= 0) working = 1'b0;
        end else if (m_upd) begin
            if (wait_left < 0) begin
                if (rnd_en) begin
                    drv_delay = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 10));
                    drv_len   = int'($urandom_range(1, 50));
                end
                wait_left = drv_never ? 1000000 : drv_delay;
            end
            if (wait_left == 0) begin
                working = 1'b1; hold_left = drv_len; wait_left = -1;
            end else begin
                wait_left--;
            end
        end else begin
            wait_left = -1;
        end
        if (rnd_en) begin
            s0_valid = ($urandom_range(0, 3) == 0);
            s1_valid = ($urandom_range(0, 3) == 0);
            s0_data  = 12'($urandom);
            s1_data  = 12'($urandom);
            clr_err  = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 199) == 0) mute = 2'($urandom);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_edge();
        check("update",      32'(update),      32'(m_upd));
        check("value0",      32'(value0),      32'(m_v0));
        check("value1",      32'(value1),      32'(m_v1));
        check("chmode0",     32'(chmode0),     32'(m_c0));
        check("chmode1",     32'(chmode1),     32'(m_c1));
        check("sample_tick", 32'(sample_tick), 32'(m_tick));
        check("overrun",     32'(overrun),     32'(m_ovr));
        check("timeout",     32'(timeout),     32'(m_tmo));
        check("ovr_cnt",     32'(ovr_cnt),     32'(m_cnt));
        drive_next();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Advance until the model accepts a new transfer; an expired budget is a failure.
    task automatic wait_accept(input int limit);
        bit found = 0;
        bit prev;
        for (int i = 0; i < limit && !found; i++) begin
            prev = m_busy;
            cycle();
            if (m_busy && !prev) found = 1;
        end
        check("wait_accept", 32'(found), 32'd1);
    endtask

    initial begin
        // Reset values.
        rst = 1'b1;
        run(3);
        check("rst_value0", 32'(value0), 32'h800);
        check("rst_update", 32'(update), 32'd0);

        // 1: s0=000, s1=FFF held before the first tick.
        rst = 1'b0;
        s0_data = 12'h000; s0_valid = 1'b1;
        s1_data = 12'hFFF; s1_valid = 1'b1;
        wait_accept(200);
        check("t1_value0", 32'(value0), 32'h800);
        check("t1_value1", 32'(value1), 32'h7FF);
        check("t1_update", 32'(update), 32'd1);

        // 2: driver responds after 3 cycles, busy for 20.
        run(60);
        check("t2_overrun", 32'(overrun), 32'd0);

        // 3: driver busy longer than a sample period drops a tick, then clear.
        drv_len = 60;
        wait_accept(200);
        run(100);
        clr_err = 1'b1;
        run(5);
        drv_len = 20;

        // 4: driver never responds; timeout then re-arm.
        drv_never = 1;
        wait_accept(200);
        run(150);
        drv_never = 0;
        run(120);

        // 5: strobe coincident with the tick is bypassed; per-channel mute.
        clr_err = 1'b1;
        cycle();
        begin
            bit ready = 0;
            for (int i = 0; i < 400 && !ready; i++) begin
                cycle();
                if (m_tick && !m_busy) ready = 1;
            end
            check("t5_wait_tick", 32'(ready), 32'd1);
        end
        s0_data = 12'h123; s0_valid = 1'b1; mute = 2'b10;
        cycle();
        check("t5_value0",  32'(value0),  32'h923);
        check("t5_chmode0", 32'(chmode0), 32'd0);
        check("t5_chmode1", 32'(chmode1), 32'd1);

        // 6: reset during the driver's busy window.
        begin
            bit in_done = 0;
            for (int i = 0; i < 200 && !in_done; i++) begin
                cycle();
                if (m_busy && m_seen && working) in_done = 1;
            end
            check("t6_wait_done", 32'(in_done), 32'd1);
        end
        rst = 1'b1;
        cycle();
        check("t6_update",  32'(update),  32'd0);
        check("t6_value0",  32'(value0),  32'h800);
        check("t6_ovr_cnt", 32'(ovr_cnt), 32'd0);
        rst = 1'b0;
        mute = 2'b00;

        // Random traffic against the model.
        rnd_en = 1;
        run(2000);
        rnd_en = 0;

`ifdef TEST_PATTERN_EN
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        test_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_accept(200);
            check("ramp_value0", 32'(value0), 32'(k));
        end
        test_en = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
